// File: rtl/clk_div_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen_if
// Brief    : Configuration request/ready bus for clk_div_gen.
// Revision : 1.0
// ============================================================================
interface clk_div_gen_if #(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = 8
) ();
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_high;
   logic [DIV_W-1:0]  cfg_phase;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
      output cfg_ready
   );
endinterface
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Brief    : Multi-channel programmable clock divider with sync and lock flag.
// Revision : 1.0
// ============================================================================
module clk_div_gen #(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 8,
   parameter int DEF_DIV     = 2,
   parameter int LOCK_CYCLES = 8
) (
   input  wire logic              refclk,
   input  wire logic              rst,
   input  wire logic              sync,
   clk_div_gen_if.slave           cfg,
   output logic [NUM_CH-1:0]      outclk,
   output logic [NUM_CH-1:0]      tick,
   output logic                   locked
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [0:0] {
      ST_SETTLE = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   logic [DIV_W-1:0] r_cnt   [NUM_CH];
   logic [DIV_W-1:0] r_div   [NUM_CH];
   logic [DIV_W-1:0] r_high  [NUM_CH];
   logic [DIV_W-1:0] r_phase [NUM_CH];

   logic             r_pend;
   logic [CH_W-1:0]  r_pend_ch;
   logic [DIV_W-1:0] r_pend_div;
   logic [DIV_W-1:0] r_pend_high;
   logic [DIV_W-1:0] r_pend_phase;
   logic             r_ready;
   lock_state_t      r_state;
   logic [7:0]       r_lock_cnt;

   logic [NUM_CH-1:0] w_wrap;
   logic [NUM_CH-1:0] w_apply;
   logic              w_xfer;
   logic              w_ch_ok;
   logic              w_capture;
   logic              w_any_apply;
   logic              w_pend_next;
   logic              w_event;
   logic [DIV_W-1:0]  w_div_eff;
   logic [DIV_W-1:0]  w_phase_eff;

   assign cfg.cfg_ready = r_ready;
   assign locked        = (r_state == ST_LOCKED);

   always_comb begin
      w_wrap  = '0;
      w_apply = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_wrap[i]  = (r_cnt[i] == (r_div[i] - DIV_W'(1)));
         w_apply[i] = r_pend && (r_pend_ch == CH_W'(i)) && (w_wrap[i] || sync);
      end
   end

   // A request to a channel index that does not exist is accepted and dropped
   assign w_xfer      = cfg.cfg_valid && r_ready;
   assign w_ch_ok     = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(NUM_CH));
   assign w_capture   = w_xfer && w_ch_ok;
   assign w_any_apply = |w_apply;
   assign w_pend_next = w_capture || (r_pend && !w_any_apply);
   assign w_event     = w_xfer || w_any_apply || sync;
   assign w_div_eff   = (cfg.cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg.cfg_div;
   assign w_phase_eff = (cfg.cfg_phase >= w_div_eff) ? '0 : cfg.cfg_phase;

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         outclk <= '0;
         tick   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i]   <= '0;
            r_div[i]   <= DIV_W'(DEF_DIV);
            r_high[i]  <= DIV_W'(DEF_DIV / 2);
            r_phase[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            outclk[i] <= (r_cnt[i] < r_high[i]);
            tick[i]   <= w_wrap[i];
            if (w_apply[i]) begin
               r_div[i]   <= r_pend_div;
               r_high[i]  <= r_pend_high;
               r_phase[i] <= r_pend_phase;
               r_cnt[i]   <= r_pend_phase;
            end else if (sync) begin
               r_cnt[i] <= r_phase[i];
            end else if (w_wrap[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_pend       <= 1'b0;
         r_pend_ch    <= '0;
         r_pend_div   <= '0;
         r_pend_high  <= '0;
         r_pend_phase <= '0;
         r_ready      <= 1'b0;
         r_state      <= ST_SETTLE;
         r_lock_cnt   <= '0;
      end else begin
         r_pend  <= w_pend_next;
         r_ready <= !w_pend_next;
         if (w_capture) begin
            r_pend_ch    <= cfg.cfg_ch;
            r_pend_div   <= w_div_eff;
            r_pend_high  <= cfg.cfg_high;
            r_pend_phase <= w_phase_eff;
         end
         case (r_state)
            ST_SETTLE: begin
               if (w_event) begin
                  r_lock_cnt <= '0;
               end else if (r_lock_cnt == 8'(LOCK_CYCLES - 1)) begin
                  r_state <= ST_LOCKED;
               end else begin
                  r_lock_cnt <= r_lock_cnt + 8'd1;
               end
            end
            ST_LOCKED: begin
               if (w_event) begin
                  r_state    <= ST_SETTLE;
                  r_lock_cnt <= '0;
               end
            end
            default: begin
               r_state    <= ST_SETTLE;
               r_lock_cnt <= '0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Brief    : Directed vector bench for clk_div_gen.
// Revision : 1.0
// ============================================================================
module tb_clk_div_gen;
   localparam int NUM_CH = 3;
   localparam int DIV_W  = 8;

   logic       refclk = 1'b0;
   logic       rst    = 1'b0;
   logic       sync   = 1'b0;
   logic [2:0] outclk;
   logic [2:0] tick;
   logic       locked;

   int n_checks = 0;
   int n_fail   = 0;

   clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_bus ();

   clk_div_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(2), .LOCK_CYCLES(8)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .sync   (sync),
      .cfg    (cfg_bus),
      .outclk (outclk),
      .tick   (tick),
      .locked (locked)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic       v;
      logic [1:0] ch;
      logic [7:0] d;
      logic [7:0] h;
      logic [7:0] p;
      logic [2:0] oc;
      logic [2:0] tk;
      logic       rdy;
      logic       lk;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mkv(logic v, logic [1:0] ch, logic [7:0] d, logic [7:0] h,
                                logic [7:0] p, logic [2:0] oc, logic [2:0] tk,
                                logic rdy, logic lk);
      vec_t r;
      r.v = v; r.ch = ch; r.d = d; r.h = h; r.p = p;
      r.oc = oc; r.tk = tk; r.rdy = rdy; r.lk = lk;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic send(input logic [1:0] ch, input logic [7:0] d, input logic [7:0] h,
                       input logic [7:0] p, input logic s);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_ch    = ch;
      cfg_bus.cfg_div   = d;
      cfg_bus.cfg_high  = h;
      cfg_bus.cfg_phase = p;
      sync              = s;
      step();
      cfg_bus.cfg_valid = 1'b0;
      sync              = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (cfg_bus.cfg_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check(name, 32'(cfg_bus.cfg_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_ch    = '0;
      cfg_bus.cfg_div   = '0;
      cfg_bus.cfg_high  = '0;
      cfg_bus.cfg_phase = '0;

      // k = edge number after reset release; row k-1 holds inputs before edge k
      vecs[0]  = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[1]  = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0);
      vecs[2]  = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[3]  = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0);
      vecs[4]  = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[5]  = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0);
      vecs[6]  = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[7]  = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 1);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 1);
      vecs[9]  = mkv(1, 1, 4, 1, 0, 3'b000, 3'b111, 0, 0);
      vecs[10] = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0);
      vecs[11] = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0);
      vecs[12] = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[13] = mkv(0, 0, 0, 0, 0, 3'b000, 3'b101, 1, 0);
      vecs[14] = mkv(0, 0, 0, 0, 0, 3'b101, 3'b000, 1, 0);
      vecs[15] = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0);
      vecs[16] = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 0);
      vecs[17] = mkv(0, 0, 0, 0, 0, 3'b000, 3'b101, 1, 0);
      vecs[18] = mkv(0, 0, 0, 0, 0, 3'b101, 3'b000, 1, 0);
      vecs[19] = mkv(0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 1);
      vecs[20] = mkv(0, 0, 0, 0, 0, 3'b111, 3'b000, 1, 1);

      step();
      step();
      check("rst_outclk", 32'(outclk), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         cfg_bus.cfg_valid = vecs[i].v;
         cfg_bus.cfg_ch    = vecs[i].ch;
         cfg_bus.cfg_div   = vecs[i].d;
         cfg_bus.cfg_high  = vecs[i].h;
         cfg_bus.cfg_phase = vecs[i].p;
         step();
         cfg_bus.cfg_valid = 1'b0;
         check($sformatf("vec%0d_outclk", i + 1), 32'(outclk), 32'(vecs[i].oc));
         check($sformatf("vec%0d_tick", i + 1), 32'(tick), 32'(vecs[i].tk));
         check($sformatf("vec%0d_ready", i + 1), 32'(cfg_bus.cfg_ready), 32'(vecs[i].rdy));
         check($sformatf("vec%0d_locked", i + 1), 32'(locked), 32'(vecs[i].lk));
      end

      // div=1 is stored as 2; high above div holds outclk at 1
      wait_ready("a_ready_pre");
      send(2'd0, 8'd1, 8'd5, 8'd0, 1'b0);
      check("a_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
      wait_ready("a_apply");
      for (int j = 1; j <= 8; j++) begin
         step();
         check("a_outclk0_high", 32'(outclk[0]), 32'd1);
         check("a_tick0", 32'(tick[0]), 32'((j % 2) == 0));
      end

      // ch0 div8 phase0, ch2 div8 phase2, then sync: ch2 leads by 2
      send(2'd0, 8'd8, 8'd4, 8'd0, 1'b0);
      wait_ready("b_apply0");
      send(2'd2, 8'd8, 8'd4, 8'd2, 1'b0);
      wait_ready("b_apply2");
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         step();
         check("b_outclk0", 32'(outclk[0]), 32'(((j - 1) % 8) < 4));
         check("b_outclk2", 32'(outclk[2]), 32'(((j + 1) % 8) < 4));
         check("b_outclk1", 32'(outclk[1]), 32'(((j - 1) % 4) < 1));
         check("b_tick0", 32'(tick[0]), 32'(((j - 1) % 8) == 7));
         check("b_tick2", 32'(tick[2]), 32'(((j + 1) % 8) == 7));
      end

      // transfer in ch1's wrap cycle applies at the following wrap
      step();
      step();
      step();
      send(2'd1, 8'd4, 8'd0, 8'd0, 1'b0);
      check("c_ready_xfer", 32'(cfg_bus.cfg_ready), 32'd0);
      check("c_tick1_xfer", 32'(tick[1]), 32'd1);
      for (int j = 1; j <= 3; j++) begin
         step();
         check("c_ready_wait", 32'(cfg_bus.cfg_ready), 32'd0);
      end
      step();
      check("c_ready_apply", 32'(cfg_bus.cfg_ready), 32'd1);
      check("c_tick1_apply", 32'(tick[1]), 32'd1);
      for (int j = 1; j <= 8; j++) begin
         step();
         check("c_outclk1_low", 32'(outclk[1]), 32'd0);
         check("c_tick1", 32'(tick[1]), 32'((j % 4) == 0));
      end

      // pending entry is applied by sync outside a wrap cycle
      send(2'd0, 8'd4, 8'd2, 8'd1, 1'b0);
      check("d_pending", 32'(cfg_bus.cfg_ready), 32'd0);
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("d_apply_sync", 32'(cfg_bus.cfg_ready), 32'd1);
      step(); check("d_oc1", 32'(outclk[0]), 32'd1); check("d_tk1", 32'(tick[0]), 32'd0);
      step(); check("d_oc2", 32'(outclk[0]), 32'd0); check("d_tk2", 32'(tick[0]), 32'd0);
      step(); check("d_oc3", 32'(outclk[0]), 32'd0); check("d_tk3", 32'(tick[0]), 32'd1);
      step(); check("d_oc4", 32'(outclk[0]), 32'd1); check("d_tk4", 32'(tick[0]), 32'd0);

      // sync with transfer in same cycle does not apply it; phase>=div stores 0
      send(2'd0, 8'd4, 8'd2, 8'd6, 1'b1);
      check("e_not_applied", 32'(cfg_bus.cfg_ready), 32'd0);
      wait_ready("e_apply_wrap");
      sync = 1'b1;
      step();
      sync = 1'b0;
      step(); check("e_oc1", 32'(outclk[0]), 32'd1);
      step(); check("e_oc2", 32'(outclk[0]), 32'd1);
      step(); check("e_oc3", 32'(outclk[0]), 32'd0);
      step(); check("e_oc4", 32'(outclk[0]), 32'd0);

      // reset while a configuration is pending discards it
      send(2'd1, 8'd8, 8'd4, 8'd0, 1'b0);
      check("f_pending", 32'(cfg_bus.cfg_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("f_rst_outclk", 32'(outclk), 32'd0);
      check("f_rst_tick", 32'(tick), 32'd0);
      check("f_rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      check("f_rst_locked", 32'(locked), 32'd0);
      step();
      step();
      rst = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         check("f_outclk", 32'(outclk), ((k % 2) == 1) ? 32'd7 : 32'd0);
         check("f_tick", 32'(tick), ((k % 2) == 0) ? 32'd7 : 32'd0);
         check("f_ready", 32'(cfg_bus.cfg_ready), 32'd1);
         check("f_locked", 32'(locked), 32'(k >= 8));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 3: number of output clock channels, 1..8.
REQ-002 Parameter DIV_W, default 8: width of divisor, high-count and phase fields.
REQ-003 Parameter DEF_DIV, default 2: reset divisor for every channel; reset high-count is DEF_DIV/2 and reset phase is 0.
REQ-004 Parameter LOCK_CYCLES, default 8: refclk cycles from settle to locked assertion, 1..255.
REQ-005 refclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset; assertion takes effect immediately, release is sampled on refclk.
REQ-007 sync  in  1  one-cycle pulse; realigns all channels.
REQ-008 cfg_valid  in  1  configuration request.
REQ-009 cfg_ready  out  1  configuration slot free.
REQ-010 cfg_ch  in  clog2(NUM_CH) (min 1)  target channel.
REQ-011 cfg_div  in  DIV_W  period in refclk cycles.
REQ-012 cfg_high  in  DIV_W  high-phase length in refclk cycles.
REQ-013 cfg_phase  in  DIV_W  counter start value after apply or sync.
REQ-014 outclk  out  NUM_CH  registered divided clocks, bit i = channel i.
REQ-015 tick  out  NUM_CH  registered one-cycle pulse per channel period.
REQ-016 locked  out  1  all channels stable for LOCK_CYCLES.

Function
REQ-017 Each channel SHALL hold a counter cnt[i] advancing by 1 per cycle and wrapping from div[i]-1 to 0.
REQ-018 outclk[i] SHALL be a flop whose value always equals (cnt[i] < high[i]); no combinational path to the output.
REQ-019 tick[i] SHALL be a flop, 1 exactly in cycles where cnt[i] == div[i]-1.
REQ-020 cfg_div values 0 and 1 SHALL be stored as 2.
REQ-021 high >= div SHALL give constant outclk 1; high == 0 SHALL give constant outclk 0; tick unaffected.
REQ-022 cfg_phase >= effective div SHALL be stored as 0.
REQ-023 A transfer occurs when cfg_valid && cfg_ready; fields are captured into a single pending slot.
REQ-024 cfg_ready SHALL be 0 from the cycle after a transfer until the cycle after the pending entry is applied.
REQ-025 Pending config SHALL apply in the target channel's next wrap cycle strictly after the transfer cycle: div/high update and cnt loads phase instead of 0; a transfer in a wrap cycle applies at the following wrap.
REQ-026 Other channels SHALL be unaffected by a transfer or apply.
REQ-027 sync SHALL load every cnt[i] with its phase[i] in the next cycle; pending config is applied at that sync instead of at wrap.
REQ-028 sync asserted in the same cycle as a transfer SHALL not apply that transfer; it applies at the next wrap.
REQ-029 Lock state machine states: SETTLE (counter counts to LOCK_CYCLES) and LOCKED; locked = 1 only in LOCKED.
REQ-030 SETTLE -> LOCKED when lock counter reaches LOCK_CYCLES; LOCKED -> SETTLE with counter cleared on transfer, apply, or sync.
REQ-031 In SETTLE, a new transfer, apply or sync SHALL clear the lock counter.

Reset
REQ-032 While rst = 0: cnt = 0, div = DEF_DIV, high = DEF_DIV/2, phase = 0, pending empty, outclk = 0 (reset high-count excluded), tick = 0, cfg_ready = 0, locked = 0, state SETTLE.
REQ-033 First cycle after release: counters run from 0, outclk reflects (0 < high), cfg_ready = 1.
REQ-034 Reset mid-operation SHALL discard any pending configuration.

Verification
REQ-035 Reset release, defaults -> all outclk toggle every cycle (period 2), tick every 2nd cycle, locked = 1 exactly 8 cycles after release.
REQ-036 cfg ch1 div=4 high=1 phase=0 -> cfg_ready low until apply, ch1 outclk 1-of-4 duty after its next wrap, ch0/ch2 unchanged, locked low then high 8 cycles after apply.
REQ-037 cfg ch0 div=1 high=5 -> stored div=2, outclk0 constant 1, tick0 every 2 cycles.
REQ-038 ch0 div=8 high=4 phase=0, ch2 div=8 high=4 phase=2, then sync -> outclk2 leads outclk0 by 2 cycles thereafter.
REQ-039 Transfer in ch1's wrap cycle -> apply at following wrap (div cycles later), not same cycle.
REQ-040 rst low while config pending -> all outputs to reset values; after release old pending never applied.
